// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: syncs and maps joystick words, debounces start/coin/pause, queues coin pulses, toggles pause.
// Optional autofire on joystick bit 9 is compiled in with INPUT_AUTOFIRE_EN.
module arcade_input_ctrl #(
  parameter int PLAYERS         = 2,
  parameter int DEBOUNCE        = 4096,
  parameter int COIN_PULSE      = 600000,
  parameter int AUTOFIRE_PERIOD = 200000
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [PLAYERS*16-1:0]  joy_in,
  input  logic                   mode_shared,
  output logic [PLAYERS-1:0]     btn_right,
  output logic [PLAYERS-1:0]     btn_left,
  output logic [PLAYERS-1:0]     btn_flap,
  output logic                   btn_start_1,
  output logic                   btn_start_2,
  output logic                   btn_coin,
  output logic                   pause,
  output logic [1:0]             coin_pending
);
  localparam logic [1:0] S_IDLE = 2'd0, S_HIGH = 2'd1, S_GAP = 2'd2;
  logic [PLAYERS*16-1:0] r_s1, r_s2;
  logic [1:0]            r_vld;
  logic [15:0]           w_or;
  logic [15:0]           w_map [PLAYERS];
  logic [3:0]            w_raw;
  logic [15:0]           r_db_cnt [4];
  logic [3:0]            r_db_lvl, r_db_lvl_d;
  logic [1:0]            r_state;
  logic [19:0]           r_coin_cnt;
  logic                  r_coin_arm;
  logic                  w_coin_rise, w_done, w_can_start, w_start;
  logic [PLAYERS-1:0]    w_af;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_vld <= '0;
    end else begin
      r_s1  <= joy_in;
      r_s2  <= r_s1;
      r_vld <= {r_vld[0], 1'b1};
    end
  always_comb begin
    w_or = '0;
    for (int p = 0; p < PLAYERS; p++) w_or = w_or | r_s2[16*p +: 16];
    for (int p = 0; p < PLAYERS; p++) w_map[p] = mode_shared ? w_or : r_s2[16*p +: 16];
  end
  // debounce lanes: 0 start1, 1 start2, 2 coin, 3 pause
  assign w_raw = {w_or[8], w_or[7], w_or[6], w_or[5]};
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
      r_db_lvl   <= '0;
      r_db_lvl_d <= '0;
    end else begin
      r_db_lvl_d <= r_db_lvl;
      for (int k = 0; k < 4; k++)
        if (w_raw[k] == r_db_lvl[k]) r_db_cnt[k] <= '0;
        else if (r_db_cnt[k] == 16'(DEBOUNCE - 1)) begin
          r_db_cnt[k] <= '0;
          r_db_lvl[k] <= w_raw[k];
        end else r_db_cnt[k] <= r_db_cnt[k] + 16'd1;
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      btn_start_1 <= 1'b0;
      btn_start_2 <= 1'b0;
      pause       <= 1'b0;
    end else begin
      btn_start_1 <= r_db_lvl[0];
      btn_start_2 <= r_db_lvl[1];
      pause       <= pause ^ (r_db_lvl[3] & ~r_db_lvl_d[3]);
    end
  // a coin held across reset stays disarmed until it is seen released
  assign w_coin_rise = r_db_lvl[2] & ~r_db_lvl_d[2] & r_coin_arm;
  assign w_done      = r_coin_cnt == 20'(COIN_PULSE - 1);
  assign w_can_start = (r_state == S_IDLE) | ((r_state == S_GAP) & w_done);
  assign w_start     = w_can_start & (w_coin_rise | (coin_pending != 2'd0));
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_coin_cnt   <= '0;
      r_coin_arm   <= 1'b0;
      btn_coin     <= 1'b0;
      coin_pending <= '0;
    end else begin
      r_coin_arm   <= r_coin_arm | (r_vld[1] & ~w_raw[2]);
      coin_pending <= w_can_start ? coin_pending - 2'((coin_pending != 2'd0) & ~w_coin_rise)
                                  : coin_pending + 2'(w_coin_rise & (coin_pending != 2'd3));
      r_coin_cnt   <= (w_start | w_done | (r_state == S_IDLE)) ? '0 : r_coin_cnt + 20'd1;
      r_state      <= w_start ? S_HIGH : w_can_start ? S_IDLE
                    : ((r_state == S_HIGH) & w_done) ? S_GAP : r_state;
      btn_coin     <= w_start | ((r_state == S_HIGH) & ~w_done);
    end
`ifdef INPUT_AUTOFIRE_EN
  logic [19:0]        r_af_cnt;
  logic               r_af_ph;
  logic [PLAYERS-1:0] w_af_hold;
  always_comb for (int p = 0; p < PLAYERS; p++) w_af_hold[p] = w_map[p][9];
  assign w_af = w_af_hold & {PLAYERS{r_af_ph}};
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_af_cnt <= '0;
      r_af_ph  <= 1'b1;
    end else if (w_af_hold == '0) begin
      r_af_cnt <= '0;
      r_af_ph  <= 1'b1;
    end else if (r_af_cnt == 20'(AUTOFIRE_PERIOD - 1)) begin
      r_af_cnt <= '0;
      r_af_ph  <= ~r_af_ph;
    end else r_af_cnt <= r_af_cnt + 20'd1;
`else
  assign w_af = '0;
`endif
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      btn_right <= '0;
      btn_left  <= '0;
      btn_flap  <= '0;
    end else
      for (int p = 0; p < PLAYERS; p++) begin
        btn_right[p] <= w_map[p][0] & ~w_map[p][1];
        btn_left[p]  <= w_map[p][1] & ~w_map[p][0];
        btn_flap[p]  <= w_map[p][4] | w_af[p];
      end
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// tb_arcade_input_ctrl: directed checks of mapping, debounce, coin queue, pause and reset behaviour.
module tb_arcade_input_ctrl;
  localparam int P = 2, D = 4, CP = 8, AF = 5;
  logic clk = 0, rst_n = 0, mode = 0;
  logic [P*16-1:0] joy = '0;
  logic [P-1:0] right, left, flap;
  logic st1, st2, coin, pz;
  logic [1:0] pend;
  int checks = 0, errors = 0;

  arcade_input_ctrl #(.PLAYERS(P), .DEBOUNCE(D), .COIN_PULSE(CP), .AUTOFIRE_PERIOD(AF)) dut (
    .clk_sys(clk), .reset_n(rst_n), .joy_in(joy), .mode_shared(mode),
    .btn_right(right), .btn_left(left), .btn_flap(flap),
    .btn_start_1(st1), .btn_start_2(st2), .btn_coin(coin), .pause(pz), .coin_pending(pend));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if ({right, left, flap} !== 6'b0) begin errors++; $display("FAIL reset_dirs: got %b expected 000000", {right, left, flap}); end
    checks++; if ({st1, st2} !== 2'b00) begin errors++; $display("FAIL reset_start: got %b expected 00", {st1, st2}); end
    checks++; if (coin !== 1'b0) begin errors++; $display("FAIL reset_coin: got %b expected 0", coin); end
    checks++; if (pz !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", pz); end
    checks++; if (pend !== 2'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pend); end
    tick(1);
    rst_n = 1;
    tick(4);
  endtask

  task automatic test_directions;
    joy[0] = 1'b1;
    tick(2);
    checks++; if (right !== 2'b00) begin errors++; $display("FAIL dir_latency: got %b expected 00", right); end
    tick(1);
    checks++; if (right !== 2'b01) begin errors++; $display("FAIL dir_own: got %b expected 01", right); end
    mode = 1'b1;
    tick(1);
    checks++; if (right !== 2'b11) begin errors++; $display("FAIL dir_shared: got %b expected 11", right); end
    mode = 1'b0;
    joy[1] = 1'b1;
    joy[17] = 1'b1;
    joy[20] = 1'b1;
    tick(3);
    checks++; if (right !== 2'b00) begin errors++; $display("FAIL neutral_right: got %b expected 00", right); end
    checks++; if (left !== 2'b10) begin errors++; $display("FAIL neutral_left: got %b expected 10", left); end
    checks++; if (flap !== 2'b10) begin errors++; $display("FAIL flap_p1: got %b expected 10", flap); end
    joy = '0;
    tick(4);
  endtask

  task automatic test_start;
    int bad;
    joy[21] = 1'b1;
    tick(6);
    checks++; if (st1 !== 1'b0) begin errors++; $display("FAIL start_early: got %b expected 0", st1); end
    tick(1);
    checks++; if ({st1, st2} !== 2'b10) begin errors++; $display("FAIL start_latency: got %b expected 10", {st1, st2}); end
    joy[21] = 1'b0;
    tick(10);
    checks++; if (st1 !== 1'b0) begin errors++; $display("FAIL start_release: got %b expected 0", st1); end
    joy[6] = 1'b1;
    tick(3);
    joy[6] = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin tick(1); if (st2) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL start_bounce: got %0d high cycles expected 0", bad); end
  endtask

  task automatic test_coin_pulse;
    int bad, first, hi, last;
    joy[7] = 1'b1;
    tick(3);
    joy[7] = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin tick(1); if (coin) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL coin_bounce: got %0d high cycles expected 0", bad); end
    joy[7] = 1'b1;
    first = 0; hi = 0; last = 0;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      if (c == 10) joy[7] = 1'b0;
      if (coin) begin hi++; last = c; if (first == 0) first = c; end
    end
    checks++; if (first !== 7) begin errors++; $display("FAIL coin_rise: got cycle %0d expected 7", first); end
    checks++; if (hi !== 8) begin errors++; $display("FAIL coin_width: got %0d expected 8", hi); end
    checks++; if (last !== 14) begin errors++; $display("FAIL coin_last: got cycle %0d expected 14", last); end
    checks++; if (pend !== 2'd0) begin errors++; $display("FAIL coin_pending_idle: got %0d expected 0", pend); end
  endtask

  task automatic test_coin_queue;
    int rises, first, prev_rise, bad_gap, hi, maxp;
    logic prev;
    rises = 0; first = 0; prev_rise = 0; bad_gap = 0; hi = 0; maxp = 0; prev = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      joy[7] = (c - 1 < 64) && ((c - 1) % 8 < 4);
      tick(1);
      if (coin) hi++;
      if (coin && !prev) begin
        rises++;
        if (first == 0) first = c;
        if (prev_rise != 0 && c - prev_rise != 16) bad_gap++;
        prev_rise = c;
      end
      if (int'(pend) > maxp) maxp = int'(pend);
      prev = coin;
    end
    checks++; if (first !== 7) begin errors++; $display("FAIL queue_first: got cycle %0d expected 7", first); end
    checks++; if (maxp !== 3) begin errors++; $display("FAIL queue_peak: got %0d expected 3", maxp); end
    checks++; if (rises !== 7) begin errors++; $display("FAIL queue_pulses: got %0d expected 7", rises); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL queue_spacing: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (hi !== 56) begin errors++; $display("FAIL queue_high_total: got %0d expected 56", hi); end
    checks++; if (pend !== 2'd0) begin errors++; $display("FAIL queue_drain: got %0d expected 0", pend); end
  endtask

  task automatic test_pause;
    joy[24] = 1'b1;
    tick(6);
    checks++; if (pz !== 1'b0) begin errors++; $display("FAIL pause_early: got %b expected 0", pz); end
    joy[24] = 1'b0;
    tick(1);
    checks++; if (pz !== 1'b1) begin errors++; $display("FAIL pause_on: got %b expected 1", pz); end
    tick(12);
    joy[8] = 1'b1;
    tick(6);
    joy[8] = 1'b0;
    tick(12);
    checks++; if (pz !== 1'b0) begin errors++; $display("FAIL pause_off: got %b expected 0", pz); end
  endtask

  task automatic test_reset_mid_pulse;
    int bad, first;
    for (int c = 1; c <= 25; c++) begin
      joy[7] = (c - 1 >= 16) || ((c - 1) % 8 < 4);
      tick(1);
    end
    checks++; if (coin !== 1'b1) begin errors++; $display("FAIL midpulse_coin: got %b expected 1", coin); end
    checks++; if (pend !== 2'd1) begin errors++; $display("FAIL midpulse_pending: got %0d expected 1", pend); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (coin !== 1'b0) begin errors++; $display("FAIL async_coin: got %b expected 0", coin); end
    checks++; if (pend !== 2'd0) begin errors++; $display("FAIL async_pending: got %0d expected 0", pend); end
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 30; c++) begin tick(1); if (coin) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL held_coin: got %0d high cycles expected 0", bad); end
    joy[7] = 1'b0;
    tick(12);
    joy[7] = 1'b1;
    first = 0;
    for (int c = 1; c <= 12; c++) begin tick(1); if (coin && first == 0) first = c; end
    checks++; if (first !== 7) begin errors++; $display("FAIL rearm_rise: got cycle %0d expected 7", first); end
    joy[7] = 1'b0;
    tick(30);
  endtask

  task automatic test_autofire;
    int bad;
    logic exp;
    bad = 0;
    joy[25] = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      tick(1);
      if (c == 30) joy[25] = 1'b0;
`ifdef INPUT_AUTOFIRE_EN
      exp = (c >= 3) && (c <= 32) && (((c - 3) % 10) < 5);
`else
      exp = 1'b0;
`endif
      if (flap !== {exp, 1'b0}) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL autofire_wave: got %0d wrong cycles expected 0", bad); end
  endtask

  initial begin
    test_reset;
    test_directions;
    test_start;
    test_coin_pulse;
    test_coin_queue;
    test_pause;
    test_reset_mid_pulse;
    test_autofire;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
